// File: rtl/i2c_slave_byte_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave_byte_rx_ctrl
// Description : I2C slave byte receiver. It requests DATA_WIDTH bits, one at a
//               time, from a bit-read submodule and assembles them MSB first.
//               The optional bit watchdog is compiled in when the macro
//               I2C_SLAVE_BYTE_RX_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave_byte_rx_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  byte_read_en,
    output logic [DATA_WIDTH-1:0] byte_read_o,
    output logic                  byte_read_err,
    output logic                  byte_read_finish,
    output logic                  bit_read_en,
    input  logic                  bit_read_i,
    input  logic                  bit_read_err,
    input  logic                  bit_read_finish
);

    localparam int                  c_CNT_W = $clog2(DATA_WIDTH);
    localparam logic [c_CNT_W-1:0]  c_LAST  = c_CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_GAP  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [c_CNT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [DATA_WIDTH-1:0]   w_shift_in;
    logic                    w_bit_done;
    logic                    w_timeout;

    // A bit is accepted only while the request is still held; a drop aborts.
    assign w_bit_done = (r_state == S_REQ) && bit_read_finish && byte_read_en;
    assign w_shift_in = {r_shift[DATA_WIDTH-2:0], bit_read_i};

`ifdef I2C_SLAVE_BYTE_RX_TIMEOUT_EN
    localparam int                 c_WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WD_W-1:0]  c_WD_LAST = c_WD_W'(TIMEOUT_CYCLES - 1);

    logic [c_WD_W-1:0] r_wdog;

    // Watchdog: restarts on each entry to REQ, counts REQ cycles without finish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog <= '0;
        end else if ((r_state != S_REQ) && (w_next_state == S_REQ)) begin
            r_wdog <= '0;
        end else if ((r_state == S_REQ) && !bit_read_finish) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    assign w_timeout = (r_state == S_REQ) && !bit_read_finish && (r_wdog == c_WD_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a dropped request wins over a completing bit.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (byte_read_en) w_next_state = S_REQ;
            end
            S_REQ: begin
                if (!byte_read_en) begin
                    w_next_state = S_IDLE;
                end else if (bit_read_finish) begin
                    if (bit_read_err)             w_next_state = S_ERR;
                    else if (r_bit_cnt == c_LAST) w_next_state = S_DONE;
                    else                          w_next_state = S_GAP;
                end else if (w_timeout) begin
                    w_next_state = S_ERR;
                end
            end
            S_GAP: begin
                if (!byte_read_en)        w_next_state = S_IDLE;
                else if (!bit_read_finish) w_next_state = S_REQ;
            end
            S_DONE:  w_next_state = S_IDLE;
            S_ERR:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath: bit counter, shift register and the published byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            byte_read_o <= '0;
        end else if ((r_state == S_IDLE) && byte_read_en) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else if (w_bit_done) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_shift   <= w_shift_in;
            // Published on entry to DONE so it is valid alongside the finish pulse.
            if (!bit_read_err && (r_bit_cnt == c_LAST)) begin
                byte_read_o <= w_shift_in;
            end
        end
    end

    // Handshake outputs registered from the next state so they track the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_read_en      <= 1'b0;
            byte_read_finish <= 1'b0;
            byte_read_err    <= 1'b0;
        end else begin
            bit_read_en      <= (w_next_state == S_REQ);
            byte_read_finish <= (w_next_state == S_DONE) || (w_next_state == S_ERR);
            byte_read_err    <= (w_next_state == S_ERR);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_byte_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_slave_byte_rx_ctrl
// Description : Directed self-checking bench for i2c_slave_byte_rx_ctrl with
//               a behavioural bit-read submodule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_byte_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       byte_read_en = 1'b0;
    logic [7:0] byte_read_o;
    logic       byte_read_err;
    logic       byte_read_finish;
    logic       bit_read_en;
    logic       bit_read_i = 1'b0;
    logic       bit_read_err = 1'b0;
    logic       bit_read_finish = 1'b0;

    int checks = 0;
    int errors = 0;

    // Bit-model controls (set by tests) and state (owned by the model).
    logic [7:0] model_byte = 8'h00;
    int         model_err_at = -1;
    logic       model_stall = 1'b0;
    int         model_idx = 0;

    // Pulse counters owned by the monitor.
    int en_pulses = 0;
    int fin_pulses = 0;
    int err_pulses = 0;
    logic prev_en = 1'b0;

`ifdef I2C_SLAVE_BYTE_RX_TIMEOUT_EN
    localparam int c_TO = 16;
`else
    localparam int c_TO = 1024;
`endif

    i2c_slave_byte_rx_ctrl #(
        .DATA_WIDTH     (8),
        .TIMEOUT_CYCLES (c_TO)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .byte_read_en     (byte_read_en),
        .byte_read_o      (byte_read_o),
        .byte_read_err    (byte_read_err),
        .byte_read_finish (byte_read_finish),
        .bit_read_en      (bit_read_en),
        .bit_read_i       (bit_read_i),
        .bit_read_err     (bit_read_err),
        .bit_read_finish  (bit_read_finish)
    );

    always #5 clk = ~clk;

    // Bit-read model: one-cycle finish per enable, MSB first, updated on negedge.
    always @(negedge clk) begin
        if (!byte_read_en || byte_read_finish) model_idx = 0;
        if (bit_read_finish) begin
            bit_read_finish = 1'b0;
            bit_read_err    = 1'b0;
        end else if (bit_read_en && !model_stall) begin
            bit_read_finish = 1'b1;
            bit_read_i      = model_byte[7 - (model_idx % 8)];
            bit_read_err    = (model_idx == model_err_at);
            model_idx       = model_idx + 1;
        end
    end

    // Pulse monitor.
    always @(negedge clk) begin
        if (bit_read_en && !prev_en) en_pulses = en_pulses + 1;
        if (byte_read_finish)        fin_pulses = fin_pulses + 1;
        if (byte_read_err)           err_pulses = err_pulses + 1;
        prev_en = bit_read_en;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Waits (bounded) for byte_read_finish; returns 0 on expiry.
    task automatic wait_finish(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (byte_read_finish) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({bit_read_en, byte_read_finish, byte_read_err, byte_read_o} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b/%b/%b/%h want 0/0/0/00",
                     bit_read_en, byte_read_finish, byte_read_err, byte_read_o);
        end
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_single_byte;
        int e0, f0, r0;
        logic ok;
        model_byte = 8'h13; model_err_at = -1;
        e0 = en_pulses; f0 = fin_pulses; r0 = err_pulses;
        byte_read_en = 1'b1;
        wait_finish(ok);
        byte_read_en = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL single_finish timed out got 0 want 1"); end
        checks++;
        if (byte_read_o !== 8'h13) begin errors++; $display("FAIL single_data got %h want 13", byte_read_o); end
        checks++;
        if (byte_read_err !== 1'b0) begin errors++; $display("FAIL single_err got %b want 0", byte_read_err); end
        tick(3);
        checks++;
        if (en_pulses - e0 !== 8) begin errors++; $display("FAIL single_en_pulses got %0d want 8", en_pulses - e0); end
        checks++;
        if (fin_pulses - f0 !== 1 || err_pulses - r0 !== 0) begin
            errors++; $display("FAIL single_pulses got fin %0d err %0d want 1 0", fin_pulses - f0, err_pulses - r0);
        end
    endtask

    task automatic test_back_to_back;
        int e0, f0;
        logic ok;
        model_byte = 8'h57; model_err_at = -1;
        e0 = en_pulses; f0 = fin_pulses;
        byte_read_en = 1'b1;
        wait_finish(ok);
        model_byte = 8'h9B;
        checks++;
        if (!ok || byte_read_o !== 8'h57) begin errors++; $display("FAIL b2b_first got %h ok %b want 57", byte_read_o, ok); end
        tick(1);
        wait_finish(ok);
        byte_read_en = 1'b0;
        checks++;
        if (!ok || byte_read_o !== 8'h9B) begin errors++; $display("FAIL b2b_second got %h ok %b want 9b", byte_read_o, ok); end
        tick(3);
        checks++;
        if (en_pulses - e0 !== 16 || fin_pulses - f0 !== 2) begin
            errors++; $display("FAIL b2b_pulses got en %0d fin %0d want 16 2", en_pulses - e0, fin_pulses - f0);
        end
    endtask

    task automatic test_bit_error;
        int e0, f0, r0;
        logic ok;
        model_byte = 8'hDF; model_err_at = -1;
        byte_read_en = 1'b1;
        wait_finish(ok);
        byte_read_en = 1'b0;
        tick(3);
        checks++;
        if (byte_read_o !== 8'hDF) begin errors++; $display("FAIL err_prior got %h want df", byte_read_o); end
        model_byte = 8'h00; model_err_at = 3;
        e0 = en_pulses; f0 = fin_pulses; r0 = err_pulses;
        byte_read_en = 1'b1;
        wait_finish(ok);
        byte_read_en = 1'b0;
        checks++;
        if (!ok || byte_read_err !== 1'b1) begin errors++; $display("FAIL err_pulse got %b ok %b want 1", byte_read_err, ok); end
        checks++;
        if (byte_read_o !== 8'hDF) begin errors++; $display("FAIL err_data_kept got %h want df", byte_read_o); end
        tick(3);
        model_err_at = -1;
        checks++;
        if (en_pulses - e0 !== 4 || fin_pulses - f0 !== 1 || err_pulses - r0 !== 1) begin
            errors++; $display("FAIL err_pulses got en %0d fin %0d err %0d want 4 1 1",
                               en_pulses - e0, fin_pulses - f0, err_pulses - r0);
        end
    endtask

    task automatic test_abort;
        int f0, r0;
        logic ok;
        model_byte = 8'hAA; model_err_at = -1;
        f0 = fin_pulses; r0 = err_pulses;
        byte_read_en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (model_idx == 4) begin ok = 1'b1; break; end
        end
        byte_read_en = 1'b0;
        tick(1);
        checks++;
        if (!ok || bit_read_en !== 1'b0) begin errors++; $display("FAIL abort_en got %b ok %b want 0", bit_read_en, ok); end
        tick(4);
        checks++;
        if (fin_pulses - f0 !== 0 || err_pulses - r0 !== 0) begin
            errors++; $display("FAIL abort_pulses got fin %0d err %0d want 0 0", fin_pulses - f0, err_pulses - r0);
        end
        model_byte = 8'h3C;
        byte_read_en = 1'b1;
        wait_finish(ok);
        byte_read_en = 1'b0;
        checks++;
        if (!ok || byte_read_o !== 8'h3C || byte_read_err !== 1'b0) begin
            errors++; $display("FAIL abort_next got %h err %b want 3c 0", byte_read_o, byte_read_err);
        end
        tick(3);
    endtask

    task automatic test_timeout;
        int n;
        int f0;
        model_stall = 1'b1;
        f0 = fin_pulses;
        byte_read_en = 1'b1;
`ifdef I2C_SLAVE_BYTE_RX_TIMEOUT_EN
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            n++;
            if (byte_read_finish) break;
        end
        checks++;
        if (n - 1 !== 16 || byte_read_err !== 1'b1 || bit_read_en !== 1'b0) begin
            errors++; $display("FAIL timeout got delay %0d err %b en %b want 16 1 0", n - 1, byte_read_err, bit_read_en);
        end
        byte_read_en = 1'b0;
`else
        n = 0;
        tick(1000);
        checks++;
        if (bit_read_en !== 1'b1 || fin_pulses - f0 !== 0) begin
            errors++; $display("FAIL no_timeout got en %b fin %0d want 1 0", bit_read_en, fin_pulses - f0);
        end
        byte_read_en = 1'b0;
`endif
        tick(3);
        model_stall = 1'b0;
    endtask

    task automatic test_reset_mid_byte;
        int f0;
        logic ok;
        model_byte = 8'hF0;
        f0 = fin_pulses;
        byte_read_en = 1'b1;
        tick(7);
        #2;
        rst_n = 1'b0;
        byte_read_en = 1'b0;
        #1;
        checks++;
        if ({bit_read_en, byte_read_finish, byte_read_err, byte_read_o} !== 11'd0) begin
            errors++; $display("FAIL async_reset got %b/%b/%b/%h want 0/0/0/00",
                               bit_read_en, byte_read_finish, byte_read_err, byte_read_o);
        end
        tick(2);
        rst_n = 1'b1;
        tick(2);
        checks++;
        if (bit_read_en !== 1'b0 || fin_pulses - f0 !== 0) begin
            errors++; $display("FAIL reset_idle got en %b fin %0d want 0 0", bit_read_en, fin_pulses - f0);
        end
        model_byte = 8'h13;
        byte_read_en = 1'b1;
        wait_finish(ok);
        byte_read_en = 1'b0;
        checks++;
        if (!ok || byte_read_o !== 8'h13) begin errors++; $display("FAIL reset_next got %h ok %b want 13", byte_read_o, ok); end
        tick(3);
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_bit_error();
        test_abort();
        test_timeout();
        test_reset_mid_byte();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
